s2mm_cmd_sequencer: RTL and testbench

S2MM_CMD_SEQUENCER -- requirements
Module: s2mm_cmd_sequencer

---
 rtl/s2mm_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_s2mm_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_cmd_sequencer.sv
// rtl/s2mm_cmd_sequencer.sv - DataMover S2MM command sequencer; optional ring-buffer wrap via S2MM_SEQ_WRAP_EN
module s2mm_cmd_sequencer #(
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] base_addr,
    input  logic [31:0] region_bytes,
    input  logic [22:0] btt_bytes,
    output logic [71:0] cmd_tdata,
    output logic        cmd_tvalid,
    input  logic        cmd_tready,
    input  logic [7:0]  sts_tdata,
    input  logic        sts_tvalid,
    output logic        sts_tready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cfg_err,
    output logic [3:0]  err_code,
    output logic [31:0] next_addr,
    output logic [31:0] cmds_issued,
    output logic [31:0] cmds_done,
    output logic [3:0]  outstanding
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, HALT} state_t;

    localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

    state_t      state;
    logic [31:0] base_r;
    logic [31:0] region_r;
    logic [22:0] btt_r;
    logic [3:0]  tag;
    logic [3:0]  exp_tag;
    logic        stop_pend;

    logic        hs;
    logic        sts_seen;
    logic        sts_acc;
    logic        sts_bad;
    logic        past_end;
    logic        cfg_bad;
    logic        can_issue;
    logic        can_start;
    logic [32:0] cmd_end;
    logic [32:0] end_addr;

    // Command word is built from registers that only move on a handshake, so it is stable while valid
    assign cmd_tdata = {4'h0, tag, next_addr, 8'h00, 1'b1, btt_r};

    assign hs        = cmd_tvalid & cmd_tready;
    assign sts_seen  = sts_tvalid & sts_tready & (state != IDLE);
    assign sts_acc   = sts_seen & (outstanding != 4'd0);
    assign sts_bad   = ~sts_tdata[7] | (sts_tdata[6:4] != 3'b000) | (sts_tdata[3:0] != exp_tag);
    assign cmd_end   = {1'b0, next_addr} + {10'd0, btt_r};
    assign end_addr  = {1'b0, base_r} + {1'b0, region_r};
    assign past_end  = cmd_end > end_addr;
    assign cfg_bad   = (btt_bytes == 23'd0) | (btt_bytes[1:0] != 2'b00) |
                       (region_bytes < {9'd0, btt_bytes});
    assign can_issue = outstanding < MAX_OUT_L;
    assign can_start = (state == IDLE) | (state == DONE) | (state == HALT);

    // Sequencer FSM, command/status accounting and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            base_r      <= 32'd0;
            region_r    <= 32'd0;
            btt_r       <= 23'd0;
            tag         <= 4'd0;
            exp_tag     <= 4'd0;
            stop_pend   <= 1'b0;
            cmd_tvalid  <= 1'b0;
            sts_tready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cfg_err     <= 1'b0;
            err_code    <= 4'd0;
            next_addr   <= 32'd0;
            cmds_issued <= 32'd0;
            cmds_done   <= 32'd0;
            outstanding <= 4'd0;
        end else begin
            sts_tready <= 1'b1;

            if (hs) begin
                cmd_tvalid  <= 1'b0;
                next_addr   <= cmd_end[31:0];
                tag         <= tag + 4'd1;
                cmds_issued <= cmds_issued + 32'd1;
            end
            if (sts_acc) begin
                cmds_done <= cmds_done + 32'd1;
                exp_tag   <= exp_tag + 4'd1;
            end
            // A simultaneous issue and completion cancel out
            case ({hs, sts_acc})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            case (state)
                ISSUE: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    // Decisions are only taken while no command is on offer
                    if (!cmd_tvalid) begin
                        if (stop || stop_pend) begin
                            state <= DRAIN;
                        end else if (past_end) begin
`ifdef S2MM_SEQ_WRAP_EN
                            next_addr <= base_r;
`else
                            state <= DRAIN;
`endif
                        end else if (can_issue) begin
                            cmd_tvalid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == 4'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Status faults abort the run; HALT keeps the first recorded fault
            if (sts_seen && state != HALT) begin
                if (outstanding == 4'd0) begin
                    err        <= 1'b1;
                    err_code   <= 4'hF;
                    state      <= HALT;
                    busy       <= 1'b0;
                    cmd_tvalid <= 1'b0;
                end else if (sts_bad) begin
                    err        <= 1'b1;
                    err_code   <= sts_tdata[7:4];
                    state      <= HALT;
                    busy       <= 1'b0;
                    cmd_tvalid <= 1'b0;
                end
            end

            if (start && can_start) begin
                base_r      <= base_addr;
                region_r    <= region_bytes;
                btt_r       <= btt_bytes;
                next_addr   <= base_addr;
                tag         <= 4'd0;
                exp_tag     <= 4'd0;
                stop_pend   <= 1'b0;
                cmd_tvalid  <= 1'b0;
                done        <= 1'b0;
                err         <= 1'b0;
                err_code    <= 4'd0;
                cmds_issued <= 32'd0;
                cmds_done   <= 32'd0;
                outstanding <= 4'd0;
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                    state   <= HALT;
                    busy    <= 1'b0;
                end else begin
                    cfg_err <= 1'b0;
                    state   <= ISSUE;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s2mm_cmd_sequencer.sv
// tb/tb_s2mm_cmd_sequencer.sv - scoreboard bench for s2mm_cmd_sequencer
module tb_s2mm_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] base_addr;
    logic [31:0] region_bytes;
    logic [22:0] btt_bytes;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid;
    logic        sts_tready;
    logic        busy;
    logic        done;
    logic        err;
    logic        cfg_err;
    logic [3:0]  err_code;
    logic [31:0] next_addr;
    logic [31:0] cmds_issued;
    logic [31:0] cmds_done;
    logic [3:0]  outstanding;

    typedef struct {
        int         due;
        logic [7:0] data;
    } sts_ev_t;

    logic [71:0] exp_q[$];
    sts_ev_t     sts_q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          err_idx = -1;
    logic [7:0]  err_byte = 8'h00;
    bit          auto_sts = 1'b1;

    s2mm_cmd_sequencer #(.MAX_OUT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .base_addr(base_addr), .region_bytes(region_bytes), .btt_bytes(btt_bytes),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
        .busy(busy), .done(done), .err(err), .cfg_err(cfg_err), .err_code(err_code),
        .next_addr(next_addr), .cmds_issued(cmds_issued), .cmds_done(cmds_done),
        .outstanding(outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end

    function automatic logic [71:0] mk_cmd(input logic [31:0] a, input logic [3:0] t, input logic [22:0] b);
        return {4'h0, t, a, 8'h00, 1'b1, b};
    endfunction

    // Command scoreboard and status responder, both evaluated on the falling edge
    initial begin : monitor
        logic [71:0] w;
        sts_ev_t     ev;
        sts_tvalid = 1'b0;
        sts_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && cmd_tvalid && cmd_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    w = cmd_tdata;
                    $display("FAIL cmd_unexpected got %h required no command", cmd_tdata);
                end else begin
                    w = exp_q.pop_front();
                    if (cmd_tdata !== w) $display("FAIL cmd_tdata[%0d] got %h required %h", hs_count, cmd_tdata, w);
                    else passed++;
                end
                if (auto_sts) begin
                    ev.due  = cyc + 4;
                    ev.data = (hs_count == err_idx) ? err_byte : {4'h8, w[67:64]};
                    sts_q.push_back(ev);
                end
                hs_count++;
            end
            if (sts_q.size() != 0 && sts_q[0].due <= cyc) begin
                ev = sts_q.pop_front();
                sts_tvalid = 1'b1;
                sts_tdata  = ev.data;
            end else begin
                sts_tvalid = 1'b0;
                sts_tdata  = 8'h00;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_sts(input logic [7:0] d, input int delay);
        sts_ev_t ev;
        ev.due  = cyc + delay;
        ev.data = d;
        sts_q.push_back(ev);
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] r, input logic [22:0] n);
        base_addr = b; region_bytes = r; btt_bytes = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            ok = done;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; cmd_tready = 1'b1;
        exp_q.delete(); sts_q.delete();
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; cmd_tready = 1'b1;
        base_addr = 32'd0; region_bytes = 32'd0; btt_bytes = 23'd0;
        tick(); tick();
        checks++; if (cmd_tvalid !== 1'b0) $display("FAIL rst_cmd_tvalid got %b required 0", cmd_tvalid); else passed++;
        checks++; if (sts_tready !== 1'b0) $display("FAIL rst_sts_tready got %b required 0", sts_tready); else passed++;
        checks++; if ({busy, done, err, cfg_err} !== 4'b0000) $display("FAIL rst_flags got %b required 0000", {busy, done, err, cfg_err}); else passed++;
        checks++; if (err_code !== 4'h0) $display("FAIL rst_err_code got %h required 0", err_code); else passed++;
        checks++; if (next_addr !== 32'd0) $display("FAIL rst_next_addr got %h required 0", next_addr); else passed++;
        checks++; if (cmds_issued !== 32'd0 || cmds_done !== 32'd0) $display("FAIL rst_counters got %0d/%0d required 0/0", cmds_issued, cmds_done); else passed++;
        checks++; if (outstanding !== 4'd0) $display("FAIL rst_outstanding got %0d required 0", outstanding); else passed++;
        reset = 1'b0;
        tick();
        checks++; if (sts_tready !== 1'b1) $display("FAIL post_rst_sts_tready got %b required 1", sts_tready); else passed++;
    endtask

    task automatic test_basic_runs();
        logic [31:0] tb_base[3]   = '{32'h0000_0000, 32'h1000_0000, 32'h0000_2000};
        logic [31:0] tb_region[3] = '{32'h0010_0000, 32'h0000_1000, 32'h0000_0048};
        logic [22:0] tb_btt[3]    = '{23'h04_0000, 23'h00_0300, 23'h00_0004};
        bit ok;
        int n;
        for (int k = 0; k < 3; k++) begin
            n = int'(tb_region[k] / {9'd0, tb_btt[k]});
            for (int i = 0; i < n; i++)
                exp_q.push_back(mk_cmd(tb_base[k] + i * tb_btt[k], 4'(i), tb_btt[k]));
            auto_sts = 1'b1;
            pulse_start(tb_base[k], tb_region[k], tb_btt[k]);
            checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL run%0d_busy got %b%b required 10", k, busy, done); else passed++;
            wait_done(1000, ok);
            checks++; if (!ok) $display("FAIL run%0d_done got 0 required 1", k); else passed++;
            checks++; if (cmds_issued !== 32'(n) || cmds_done !== 32'(n)) $display("FAIL run%0d_counts got %0d/%0d required %0d", k, cmds_issued, cmds_done, n); else passed++;
            checks++; if (next_addr !== tb_base[k] + n * tb_btt[k]) $display("FAIL run%0d_next_addr got %h required %h", k, next_addr, tb_base[k] + n * tb_btt[k]); else passed++;
            checks++; if (outstanding !== 4'd0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL run%0d_idle got out=%0d busy=%b err=%b required 0", k, outstanding, busy, err); else passed++;
            checks++; if (exp_q.size() != 0) $display("FAIL run%0d_missing got %0d left required 0", k, exp_q.size()); else passed++;
            exp_q.delete();
        end
    endtask

    task automatic test_max_out();
        bit ok;
        int h0;
        auto_sts = 1'b0;
        h0 = hs_count;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_cmd(32'h40000 * i, 4'(i), 23'h40000));
        pulse_start(32'h0, 32'h100000, 23'h40000);
        repeat (20) tick();
        checks++; if (hs_count - h0 != 2) $display("FAIL maxout_issued got %0d required 2", hs_count - h0); else passed++;
        checks++; if (outstanding !== 4'd2 || cmd_tvalid !== 1'b0) $display("FAIL maxout_hold got out=%0d valid=%b required 2/0", outstanding, cmd_tvalid); else passed++;
        push_sts(8'h80, 0);
        repeat (20) tick();
        checks++; if (hs_count - h0 != 3) $display("FAIL maxout_one_more got %0d required 3", hs_count - h0); else passed++;
        checks++; if (outstanding !== 4'd2) $display("FAIL maxout_out2 got %0d required 2", outstanding); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push_sts(8'h81, 0);
        push_sts(8'h82, 2);
        wait_done(100, ok);
        checks++; if (!ok || cmds_done !== 32'd3 || hs_count - h0 != 3) $display("FAIL stop_drain got done=%b cmds_done=%0d required 1/3", ok, cmds_done); else passed++;
        auto_sts = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_underflow();
        push_sts(8'h80, 0);
        tick(); tick(); tick();
        checks++; if (err !== 1'b1 || err_code !== 4'hF) $display("FAIL underflow_err got %b/%h required 1/F", err, err_code); else passed++;
        checks++; if (outstanding !== 4'd0 || cmds_done !== 32'd3) $display("FAIL underflow_counts got %0d/%0d required 0/3", outstanding, cmds_done); else passed++;
    endtask

    task automatic test_status_error();
        bit seen;
        int h0;
        err_idx  = hs_count + 1;
        err_byte = 8'h21;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_cmd(32'h40000 * i, 4'(i), 23'h40000));
        pulse_start(32'h0, 32'h100000, 23'h40000);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = err;
        end
        checks++; if (!seen) $display("FAIL sts_err_wait got 0 required 1"); else passed++;
        checks++; if (err_code !== 4'h2 || busy !== 1'b0 || cfg_err !== 1'b0) $display("FAIL sts_err_code got %h busy=%b required 2/0", err_code, busy); else passed++;
        h0 = hs_count;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_tvalid) seen = 1'b1;
        end
        checks++; if (seen || hs_count != h0) $display("FAIL halt_no_cmd got valid_seen=%b required 0", seen); else passed++;
        checks++; if (outstanding !== 4'd0) $display("FAIL halt_drain got %0d required 0", outstanding); else passed++;
        err_idx = -1;
        exp_q.delete();
    endtask

    task automatic test_cfg_err();
        logic [31:0] r[3] = '{32'h100, 32'h10, 32'h100};
        logic [22:0] b[3] = '{23'h3, 23'h40, 23'h0};
        bit seen;
        for (int k = 0; k < 3; k++) begin
            pulse_start(32'h0, r[k], b[k]);
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (cmd_tvalid) seen = 1'b1;
                tick();
            end
            checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || err !== 1'b0) $display("FAIL cfg%0d got cfg_err=%b busy=%b required 1/0", k, cfg_err, busy); else passed++;
            checks++; if (seen) $display("FAIL cfg%0d_valid got 1 required 0", k); else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        apply_reset();
        cmd_tready = 1'b0;
        pulse_start(32'h0, 32'h100000, 23'h40000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = cmd_tvalid;
        end
        checks++; if (!seen) $display("FAIL midrun_valid got 0 required 1"); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (cmd_tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL midrun_async got valid=%b busy=%b required 0/0", cmd_tvalid, busy); else passed++;
        checks++; if (next_addr !== 32'd0 || cmds_issued !== 32'd0 || outstanding !== 4'd0) $display("FAIL midrun_clear got %h/%0d/%0d required 0", next_addr, cmds_issued, outstanding); else passed++;
        tick();
        reset = 1'b0;
        cmd_tready = 1'b1;
        exp_q.delete(); sts_q.delete();
        tick();
    endtask

`ifdef S2MM_SEQ_WRAP_EN
    task automatic test_wrap();
        bit ok;
        int h0;
        h0 = hs_count;
        for (int i = 0; i < 6; i++) exp_q.push_back(mk_cmd(32'h40000 * (i % 4), 4'(i), 23'h40000));
        pulse_start(32'h0, 32'h100000, 23'h40000);
        for (int i = 0; i < 300 && hs_count - h0 < 5; i++) tick();
        checks++; if (hs_count - h0 != 5) $display("FAIL wrap_fifth got %0d required 5", hs_count - h0); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL wrap_no_done got %b required 0", done); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok || hs_count - h0 != 5 || outstanding !== 4'd0) $display("FAIL wrap_stop got done=%b n=%0d required 1/5", ok, hs_count - h0); else passed++;
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_runs();
        test_max_out();
        test_underflow();
        test_status_error();
        test_cfg_err();
        test_reset_midrun();
`ifdef S2MM_SEQ_WRAP_EN
        test_wrap();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
